// File: rtl/frame_config_sequencer_if.sv
// Word stream handshake from the bitstream loader into the column configuration sequencer.
// The master drives words with a valid; the sequencer returns ready.
interface frame_config_sequencer_if #(
  parameter int W = 32
);
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/frame_config_sequencer.sv
// Column config sequencer: header + NumberOfRows words -> FrameData, strobe 2 cycles after last word, ready back after 3.
// Backpressure: in_ready low during SETUP/STROBE/HOLD. Optional running word checksum under FRAME_CFG_CHECKSUM_EN.
module frame_config_sequencer #(
  parameter int FrameBitsPerRow = 32,
  parameter int MaxFramesPerCol = 20,
  parameter int NumberOfRows    = 16,
  parameter int ColBits         = 8
) (
  input  logic                                    UserCLK,
  input  logic                                    resetn,
  frame_config_sequencer_if.slave                 in_if,
  output logic [NumberOfRows*FrameBitsPerRow-1:0] FrameData,
  output logic [MaxFramesPerCol-1:0]              FrameStrobe,
  output logic [ColBits-1:0]                      col_sel,
  output logic                                    cfg_busy,
  output logic                                    cfg_done,
`ifdef FRAME_CFG_CHECKSUM_EN
  output logic [FrameBitsPerRow-1:0]              cfg_checksum,
`endif
  output logic                                    cfg_err
);

  localparam int RowW = (NumberOfRows > 1) ? $clog2(NumberOfRows) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, SETUP, STROBE, HOLD} state_t;

  state_t                                 state_q;
  logic [NumberOfRows*FrameBitsPerRow-1:0] frame_data_q;
  logic [MaxFramesPerCol-1:0]             strobe_q;
  logic [ColBits-1:0]                     col_sel_q;
  logic [4:0]                             frame_idx_q;
  logic [RowW-1:0]                        row_cnt_q;
  logic                                   discard_q;
  logic                                   in_ready_q;
  logic                                   busy_q;
  logic                                   done_q;
  logic                                   err_q;

  logic       accept;
  logic       is_hdr;
  logic       is_end;
  logic [4:0] hdr_idx;

  assign accept  = in_if.in_valid && in_ready_q;
  assign is_hdr  = in_if.in_data[FrameBitsPerRow-1];
  assign is_end  = in_if.in_data[FrameBitsPerRow-2];
  assign hdr_idx = in_if.in_data[20:16];

  always_ff @(posedge UserCLK or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      frame_data_q <= '0;
      strobe_q     <= '0;
      col_sel_q    <= '0;
      frame_idx_q  <= '0;
      row_cnt_q    <= '0;
      discard_q    <= 1'b0;
      in_ready_q   <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          // Non-header words in IDLE are swallowed silently.
          if (accept && is_hdr) begin
            if (is_end) begin
              done_q <= 1'b1;
            end else begin
              col_sel_q   <= in_if.in_data[ColBits-1:0];
              frame_idx_q <= hdr_idx;
              row_cnt_q   <= '0;
              discard_q   <= (int'(hdr_idx) >= MaxFramesPerCol);
              if (int'(hdr_idx) >= MaxFramesPerCol) err_q <= 1'b1;
              busy_q      <= 1'b1;
              state_q     <= LOAD;
            end
          end
        end
        LOAD: begin
          if (accept) begin
            frame_data_q[int'(row_cnt_q)*FrameBitsPerRow +: FrameBitsPerRow] <= in_if.in_data;
            row_cnt_q <= row_cnt_q + RowW'(1);
            if (row_cnt_q == RowW'(NumberOfRows-1)) begin
              in_ready_q <= 1'b0;
              state_q    <= SETUP;
            end
          end
        end
        SETUP: begin
          strobe_q <= discard_q ? '0 : (MaxFramesPerCol'(1) << frame_idx_q);
          state_q  <= STROBE;
        end
        STROBE: begin
          strobe_q <= '0;
          state_q  <= HOLD;
        end
        HOLD: begin
          in_ready_q <= 1'b1;
          busy_q     <= 1'b0;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef FRAME_CFG_CHECKSUM_EN
  logic [FrameBitsPerRow-1:0] checksum_q;

  always_ff @(posedge UserCLK or negedge resetn) begin
    if (!resetn) begin
      checksum_q <= '0;
    end else if (accept) begin
      checksum_q <= checksum_q + in_if.in_data;
    end
  end

  assign cfg_checksum = checksum_q;
`endif

  assign in_if.in_ready = in_ready_q;
  assign FrameData      = frame_data_q;
  assign FrameStrobe    = strobe_q;
  assign col_sel        = col_sel_q;
  assign cfg_busy       = busy_q;
  assign cfg_done       = done_q;
  assign cfg_err        = err_q;

endmodule
